// File: rtl/a133x_pkg.sv
// Shared types and default constants for the A133X velocity estimator.
package a133x_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    UPDATE  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  localparam int DEFAULT_NUMBER_OF_SENSORS = 1;
  localparam int DEFAULT_WINDOW            = 64;
  localparam int DEFAULT_COUNTS_PER_REV    = 4096;

endpackage

// File: rtl/a133x_wrap_delta.sv
// Angle difference between two samples, folded back into the half-revolution
// range so a crossing of the 0 / COUNTS_PER_REV-1 boundary reads as a small step.
module a133x_wrap_delta
  import a133x_pkg::*;
#(
  parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV
) (
  input  logic        [31:0] angle,
  input  logic        [31:0] prev,
  output logic signed [31:0] delta
);

  localparam logic signed [31:0] REV      = 32'(COUNTS_PER_REV);
  localparam logic signed [31:0] HALF     = 32'(COUNTS_PER_REV / 2);
  localparam logic signed [31:0] NEG_HALF = -HALF;

  logic signed [31:0] raw;

  assign raw = $signed(angle - prev);

  // Exactly +/- half a revolution is ambiguous and is passed through as-is.
  always_comb begin
    delta = raw;
    if (raw > HALF) begin
      delta = raw - REV;
    end else if (raw < NEG_HALF) begin
      delta = raw + REV;
    end
  end

endmodule

// File: rtl/a133x_velocity_estimator.sv
// Multi-channel encoder velocity estimator: accumulates wrap-corrected angle
// deltas per channel and publishes the sum every WINDOW deltas.
module a133x_velocity_estimator
  import a133x_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = DEFAULT_NUMBER_OF_SENSORS,
  parameter int WINDOW            = DEFAULT_WINDOW,
  parameter int COUNTS_PER_REV    = DEFAULT_COUNTS_PER_REV
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        angle_valid,
  output logic        angle_ready,
  input  logic [7:0]  angle_sensor,
  input  logic [31:0] angle_in,
  input  logic        zero_velocity,
  input  logic [7:0]  sensor,
  output logic [31:0] sensor_velocity,
  output logic        velocity_strobe,
  output logic [7:0]  velocity_sensor,
  output logic        index_error
);

  // Channel storage is rounded up to a power of two so the index width matches
  // the array depth exactly; entries beyond NUMBER_OF_SENSORS are never addressed.
  localparam int         CH_W  = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;
  localparam int         DEPTH = 1 << CH_W;
  localparam int         CNT_W = $clog2(WINDOW);
  localparam logic [8:0] NUM_S = 9'(NUMBER_OF_SENSORS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t state;

  logic        [31:0]      prev_q   [DEPTH];
  logic signed [31:0]      acc_q    [DEPTH];
  logic        [CNT_W-1:0] count_q  [DEPTH];
  logic                    primed_q [DEPTH];
  logic signed [31:0]      velocity [DEPTH];

  logic        [CH_W-1:0]  ch_w;
  logic        [31:0]      angle_w;
  logic        [31:0]      prev_w;
  logic signed [31:0]      acc_w;
  logic        [CNT_W-1:0] count_w;
  logic                    primed_w;

  logic signed [31:0] delta;
  logic signed [31:0] acc_next;

  a133x_wrap_delta #(
    .COUNTS_PER_REV(COUNTS_PER_REV)
  ) u_wrap_delta (
    .angle(angle_w),
    .prev (prev_w),
    .delta(delta)
  );

  assign acc_next    = acc_w + delta;
  assign angle_ready = (state == IDLE) && !reset;

  // Readout mux; unknown channels read as zero velocity.
  always_comb begin
    sensor_velocity = '0;
    if ({1'b0, sensor} < NUM_S) begin
      sensor_velocity = velocity[sensor[CH_W-1:0]];
    end
  end

  // Sample FSM and per-channel state update; zero_velocity overrides everything
  // except reset and deliberately leaves index_error untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      velocity_strobe <= 1'b0;
      velocity_sensor <= '0;
      index_error     <= 1'b0;
      ch_w            <= '0;
      angle_w         <= '0;
      prev_w          <= '0;
      acc_w           <= '0;
      count_w         <= '0;
      primed_w        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        prev_q[i]   <= '0;
        acc_q[i]    <= '0;
        count_q[i]  <= '0;
        primed_q[i] <= 1'b0;
        velocity[i] <= '0;
      end
    end else begin
      velocity_strobe <= 1'b0;
      if (zero_velocity) begin
        state <= IDLE;
        for (int i = 0; i < DEPTH; i++) begin
          acc_q[i]    <= '0;
          count_q[i]  <= '0;
          primed_q[i] <= 1'b0;
          velocity[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (angle_valid) begin
              if ({1'b0, angle_sensor} < NUM_S) begin
                ch_w    <= angle_sensor[CH_W-1:0];
                angle_w <= angle_in;
                state   <= LOAD;
              end else begin
                index_error <= 1'b1;
              end
            end
          end
          LOAD: begin
            prev_w   <= prev_q[ch_w];
            acc_w    <= acc_q[ch_w];
            count_w  <= count_q[ch_w];
            primed_w <= primed_q[ch_w];
            state    <= UPDATE;
          end
          UPDATE: begin
            prev_q[ch_w] <= angle_w;
            if (!primed_w) begin
              primed_q[ch_w] <= 1'b1;
              state          <= IDLE;
            end else begin
              acc_q[ch_w]   <= acc_next;
              acc_w         <= acc_next;
              count_q[ch_w] <= count_w + 1'b1;
              state         <= (count_w == LAST_CNT) ? PUBLISH : IDLE;
            end
          end
          PUBLISH: begin
            velocity[ch_w]  <= acc_w;
            acc_q[ch_w]     <= '0;
            count_q[ch_w]   <= '0;
            velocity_strobe <= 1'b1;
            velocity_sensor <= 8'(ch_w);
            state           <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/a133x_velocity_estimator.md
A133X_VELOCITY_ESTIMATOR -- requirements
Module: a133x_velocity_estimator

Interface
REQ-001 Parameter NUMBER_OF_SENSORS, default 1: number of encoder channels tracked.
REQ-002 Parameter WINDOW, default 64: samples per velocity estimate; power of two, at least 2.
REQ-003 Parameter COUNTS_PER_REV, default 4096: raw angle range; WINDOW*COUNTS_PER_REV/2 SHALL be below 2^31.
REQ-004 clock  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 angle_valid  in  1  upstream sample strobe.
REQ-007 angle_ready  out  1  block can accept a sample.
REQ-008 angle_sensor  in  8  channel index of the sample.
REQ-009 angle_in  in  32  raw angle, 0..COUNTS_PER_REV-1.
REQ-010 zero_velocity  in  1  clears all channel state.
REQ-011 sensor  in  8  readout channel select.
REQ-012 sensor_velocity  out  32  signed counts per window of the selected channel.
REQ-013 velocity_strobe  out  1  one-cycle pulse on publish.
REQ-014 velocity_sensor  out  8  channel that published.
REQ-015 index_error  out  1  sticky flag for an out-of-range angle_sensor.

Function
REQ-016 FSM states: IDLE, LOAD, UPDATE, PUBLISH; angle_ready=1 only in IDLE.
REQ-017 Accept on angle_valid&angle_ready: capture angle_in and angle_sensor, go to LOAD; each sample is accepted exactly once.
REQ-018 angle_sensor>=NUMBER_OF_SENSORS: sample dropped, index_error<=1, FSM stays IDLE, no channel state changes.
REQ-019 LOAD: fetch the channel's prev, acc, count and primed into working registers; go to UPDATE.
REQ-020 UPDATE, primed=0: prev<=angle, primed<=1, acc and count unchanged; go to IDLE.
REQ-021 UPDATE, primed=1: delta=angle-prev, 32-bit signed arithmetic.
REQ-022 Wrap correction: if delta>COUNTS_PER_REV/2, subtract COUNTS_PER_REV; if delta<-COUNTS_PER_REV/2, add COUNTS_PER_REV; delta equal to +/-COUNTS_PER_REV/2 passes unchanged.
REQ-023 In the same UPDATE: acc+=delta, count+=1, prev<=angle; if the old count==WINDOW-1 go to PUBLISH, else go to IDLE.
REQ-024 PUBLISH: velocity[ch]<=acc including this delta; acc<=0; count<=0; velocity_strobe=1; velocity_sensor=ch; go to IDLE.
REQ-025 Latency: accept edge to velocity_strobe high is 3 cycles. Throughput: one sample per 3 cycles, or 4 cycles when publishing.
REQ-026 sensor_velocity is a combinational mux of velocity[sensor]; it reads 0 when sensor>=NUMBER_OF_SENSORS.
REQ-027 zero_velocity has priority. In its cycle it clears primed, acc, count and velocity for all channels, aborts any in-flight sample, forces IDLE and suppresses any accept or strobe in that cycle. index_error is not cleared.
REQ-028 No saturation logic; REQ-003 guarantees acc cannot overflow.

Reset
REQ-029 On reset: FSM=IDLE; angle_ready=0 during reset; all per-channel prev, acc, count, primed and velocity = 0; velocity_strobe=0; velocity_sensor=0; index_error=0.
REQ-030 angle_ready=1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-sample discards that sample with no partial writes.

Structure
REQ-032 Shared package a133x_pkg holds the FSM state enum and default constants (COUNTS_PER_REV, WINDOW).
REQ-033 The wrap-corrected subtraction (REQ-021, REQ-022) is a combinational sub-module a133x_wrap_delta.
REQ-034 Per-channel state is held in register arrays indexed by channel.

Verification (NUMBER_OF_SENSORS=2, WINDOW=4, COUNTS_PER_REV=4096)
REQ-035 Ch0 angles 100,110,120,130,140 -> first sample only primes; strobe 3 cycles after accepting 140; velocity_sensor=0; sensor_velocity=40.
REQ-036 Ch0 angles 4090,4,14,24,34 -> 40. Ch0 angles 5,4091,4081,4071,4061 -> -40.
REQ-037 Interleaved ch0 +10/sample and ch1 -3/sample -> ch0=40 and ch1=-12, each strobe carrying the correct velocity_sensor.
REQ-038 zero_velocity after 3 ch0 samples -> both velocities 0; the next sample re-primes; 4 further deltas are needed before a strobe.
REQ-039 angle_sensor=5 -> index_error=1 and stays 1; angle_ready returns 1 next cycle; no strobe; velocities unchanged.
REQ-040 angle_valid held high for 10 samples -> angle_ready high 1 cycle in every 3 (4 at publish); exactly 10 accepts.
